// File: rtl/tribus_pkg.sv
// Shared types for the tri-state bus arbiter: FSM state encoding and counter widths.
// No timing of its own; pure declarations.
package tribus_pkg;
    localparam int HOLD_W = 8;
    localparam int TURN_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
// Zero latency; no backpressure, o_any simply reports whether anyone asked.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic               w_found;

    // Lower copy masked below the pointer, upper copy unmasked, so a single
    // low-to-high priority scan yields the wrapped round-robin winner.
    always_comb begin
        w_dbl = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_dbl[j]         = i_req[j] && (IDX_W'(j) >= i_ptr);
            w_dbl[N_REQ + j] = i_req[j];
        end
    end

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < 2*N_REQ; k++) begin
            if (w_dbl[k] && !w_found) begin
                w_found = 1'b1;
                o_idx   = IDX_W'(k % N_REQ);
            end
        end
    end

    always_comb begin
        o_win = '0;
        for (int j = 0; j < N_REQ; j++) begin
            o_win[j] = w_found && (o_idx == IDX_W'(j));
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state net, with hold limit and driver-free turnaround.
// Grant one cycle after request in IDLE; requests are ignored while DRIVE/TURN occupy the bus.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     timeout
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [HOLD_W-1:0]  r_hold;
    logic [TURN_W-1:0]  r_turn;
    logic               r_busy;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [TURN_W-1:0]  w_turn_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;

    logic [N_REQ-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_rel_norm;
    logic               w_limit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_rel_norm = done[r_owner] || !req[r_owner];
    assign w_limit    = (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_turn_nxt    = r_turn;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = DRIVE;
                    w_gnt_nxt   = w_win;
                    w_owner_nxt = w_idx;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            DRIVE: begin
                if (w_rel_norm || w_limit) begin
                    w_state_nxt   = TURN;
                    w_gnt_nxt     = '0;
                    w_ptr_nxt     = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                    w_turn_nxt    = '0;
                    // A voluntary release wins over a coincident limit hit.
                    w_timeout_nxt = w_limit && !w_rel_norm;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            TURN: begin
                if (r_turn == TURN_W'(TURN_CYC - 1)) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_turn_nxt  = '0;
                end else begin
                    w_turn_nxt = r_turn + TURN_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_turn    <= w_turn_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign oe       = r_gnt;
    assign owner    = r_owner;
    assign bus_busy = r_busy;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a reference model.
module tb_tribus_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;
    localparam int TC = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [N-1:0]  oe;
    logic [IW-1:0] owner;
    logic          bus_busy;
    logic          timeout;

    tribus_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH),
        .TURN_CYC (TC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .oe       (oe),
        .owner    (owner),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus, how long they've held it, how much gap remains.
    bit m_active;
    int m_own;
    int m_ptr;
    int m_held;
    int m_gap;
    bit m_to;
    int wait_cnt [N];

    logic [N-1:0] e_oe;
    logic [N-1:0] rnd_req;
    logic [N-1:0] rnd_done;
    logic         rnd_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] rq, input logic [N-1:0] dn, input logic r);
        if (r) begin
            m_active = 1'b0;
            m_own    = 0;
            m_ptr    = 0;
            m_held   = 0;
            m_gap    = 0;
            m_to     = 1'b0;
            for (int j = 0; j < N; j++) wait_cnt[j] = 0;
        end else if (m_active) begin
            bit norm;
            bit lim;
            norm = dn[m_own] || !rq[m_own];
            lim  = (m_held + 1 == MH);
            if (norm || lim) begin
                m_active = 1'b0;
                m_gap    = TC;
                m_to     = lim && !norm;
                m_ptr    = (m_own + 1) % N;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (rq != '0) begin
                int w;
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                end
                for (int j = 0; j < N; j++) begin
                    if (j != w && rq[j]) wait_cnt[j]++;
                    else wait_cnt[j] = 0;
                    chk("no_starve", 32'(wait_cnt[j] < N), 32'd1);
                end
                m_active = 1'b1;
                m_own    = w;
                m_held   = 0;
            end
        end
    endtask

    task automatic compare();
        e_oe = m_active ? N'(1 << m_own) : '0;
        chk("m_gnt",     32'(gnt),       32'(e_oe));
        chk("m_oe",      32'(oe),        32'(e_oe));
        chk("m_owner",   32'(owner),     32'(m_own));
        chk("m_busy",    32'(bus_busy),  32'(m_active || m_gap > 0));
        chk("m_timeout", 32'(timeout),   32'(m_to));
        chk("onehot0",   32'($onehot0(oe)), 32'd1);
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] dn, input logic r);
        req  = rq;
        done = dn;
        rst  = r;
        @(posedge clk);
        model_edge(rq, dn, r);
        #1;
        compare();
    endtask

    initial begin
        req  = '0;
        done = '0;
        rst  = 1'b1;

        // Reset state
        step(4'h0, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        chk("rst_oe",    32'(oe),       32'd0);
        chk("rst_owner", 32'(owner),    32'd0);
        chk("rst_busy",  32'(bus_busy), 32'd0);
        chk("rst_to",    32'(timeout),  32'd0);

        // Single requester, released by done after four drive cycles
        step(4'h0, 4'h0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            step(4'b0001, 4'h0, 1'b0);
            chk("single_oe", 32'(oe), 32'b0001);
        end
        step(4'b0001, 4'b0001, 1'b0);
        chk("single_rel_oe",   32'(oe),       32'd0);
        chk("single_rel_busy", 32'(bus_busy), 32'd1);
        chk("single_rel_to",   32'(timeout),  32'd0);
        for (int s = 0; s < TC; s++) step(4'h0, 4'h0, 1'b0);
        chk("single_idle_busy", 32'(bus_busy), 32'd0);

        // All four requesting, each releases on its second drive cycle
        step(4'h0, 4'h0, 1'b1);
        for (int s = 0; s < 5 * (TC + 3); s++) begin
            step(4'hF, (s % (TC + 3) == 2) ? N'(1 << ((s / (TC + 3)) % N)) : 4'h0, 1'b0);
            chk("rr_oe", 32'(oe), (s % (TC + 3) < 2) ? 32'(1 << ((s / (TC + 3)) % N)) : 32'd0);
        end

        // Hold limit: agent 2 alone, never releasing voluntarily
        step(4'h0, 4'h0, 1'b1);
        for (int s = 0; s < 2 * (MH + TC + 1); s++) begin
            step(4'b0100, 4'h0, 1'b0);
            chk("hold_oe", 32'(oe), (s % (MH + TC + 1) < MH) ? 32'b0100 : 32'd0);
            chk("hold_to", 32'(timeout), 32'(s % (MH + TC + 1) == MH));
        end

        // Turnaround: agent 1 asks during TURN and must wait until after IDLE
        step(4'h0, 4'h0, 1'b1);
        step(4'b0001, 4'h0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0);
        chk("turn0_oe", 32'(oe), 32'd0);
        for (int s = 0; s < TC - 1; s++) begin
            step(4'b0010, 4'h0, 1'b0);
            chk("turn_oe",   32'(oe),       32'd0);
            chk("turn_busy", 32'(bus_busy), 32'd1);
        end
        step(4'b0010, 4'h0, 1'b0);
        chk("turn_idle_oe",   32'(oe),       32'd0);
        chk("turn_idle_busy", 32'(bus_busy), 32'd0);
        step(4'b0010, 4'h0, 1'b0);
        chk("turn_regrant_oe",    32'(oe),    32'b0010);
        chk("turn_regrant_owner", 32'(owner), 32'd1);

        // Reset during DRIVE drops oe at once and restarts the pointer
        step(4'h0, 4'h0, 1'b1);
        for (int s = 0; s < 3; s++) step(4'b0100, 4'h0, 1'b0);
        chk("mid_drive_oe", 32'(oe), 32'b0100);
        step(4'b0100, 4'h0, 1'b1);
        chk("mid_rst_oe",    32'(oe),       32'd0);
        chk("mid_rst_owner", 32'(owner),    32'd0);
        chk("mid_rst_busy",  32'(bus_busy), 32'd0);
        step(4'b0110, 4'h0, 1'b0);
        chk("post_rst_oe",    32'(oe),    32'b0010);
        chk("post_rst_owner", 32'(owner), 32'd1);

        // Random traffic
        rnd_req = '0;
        for (int s = 0; s < 10000; s++) begin
            rnd_req  = rnd_req ^ (N'($urandom) & N'($urandom) & N'($urandom));
            rnd_done = N'($urandom) & N'($urandom);
            rnd_rst  = ($urandom_range(0, 499) == 0);
            step(rnd_req, rnd_done, rnd_rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
